uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/uart_rx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions. Holds the receiver FSM state type, the
//            oversampling ratio, the sample positions inside a bit, the
//            clock-divider calculation and a 2-of-3 majority helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  // Oversample positions within one bit period.
  localparam logic [3:0] S_LO  = 4'd7;
  localparam logic [3:0] S_MID = 4'd8;
  localparam logic [3:0] S_HI  = 4'd9;
  localparam logic [3:0] S_END = 4'd15;

  // Clock cycles per oversample tick (integer-truncated).
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word fall-through FIFO. rdata_o always shows
//            the head entry (zero while empty). A write while full is refused
//            unless a read happens in the same cycle; a read while empty is
//            ignored.
// Ports    : clk_i, rst_i (async, active-high)
//            wr_i / wdata_i  : push strobe and data
//            rd_i            : pop strobe
//            rdata_o         : head entry
//            full_o, empty_o : occupancy status
//            count_o         : registered occupancy (0..2**DEPTH_LOG2)
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  rd_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned              DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]    PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]      CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]      CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push.
  assign w_do_rd = rd_i & ~empty_o;
  assign w_do_wr = wr_i & (~full_o | w_do_rd);

  // Stale memory is never exposed: the head reads as zero while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_wr) wptr_q <= wptr_q + PTR_ONE;
      if (w_do_rd) rptr_q <= rptr_q + PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Debug UART receiver. Synchronises the serial line, deframes 8N1
//            characters with 16x oversampling and 2-of-3 majority sampling,
//            and queues received bytes in a first-word fall-through FIFO.
//            Framing and overrun errors are held in sticky flags.
// Ports    : I_clk, I_rst (async, active-high)
//            I_uart_rx   : serial line, idle high, asynchronous to I_clk
//            I_read      : pop strobe (ignored while O_valid=0)
//            I_clear     : clears both sticky flags
//            O_data      : FIFO head byte, O_valid : FIFO not empty
//            O_count     : FIFO occupancy
//            O_frame_err : stop bit sampled low, O_overrun : byte lost (full)
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_uart_rx,
  input  logic                I_read,
  input  logic                I_clear,
  output logic [7:0]          O_data,
  output logic                O_valid,
  output logic [DEPTH_LOG2:0] O_count,
  output logic                O_frame_err,
  output logic                O_overrun
);

  localparam int unsigned      DIV      = calc_div(CLK_HZ, BAUD);
  localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic             rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             w_tick, w_cnt_clr;
  rx_state_e        state_q, state_d;
  logic [3:0]       samp_q, samp_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       win_q, win_d, w_win_shift;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_q, push_d;
  logic             frame_err_q, overrun_q;
  logic             w_frame_set, w_overrun_set;
  logic             w_full, w_empty;

  assign w_tick      = (div_cnt_q == DIV_LAST);
  // Window contents including the sample being taken on this tick; used
  // where the majority decision is made on the last sample itself.
  assign w_win_shift = {win_q[1:0], rx_sync_q};

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      rx_meta_q <= I_uart_rx;
      rx_sync_q <= rx_meta_q;
      // Restarting on the start edge puts the sample points at a fixed
      // phase relative to the incoming character.
      if (w_cnt_clr || w_tick) div_cnt_q <= '0;
      else                     div_cnt_q <= div_cnt_q + DIV_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    win_d       = win_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_frame_set = 1'b0;

    if (w_tick && (samp_q == S_LO || samp_q == S_MID || samp_q == S_HI)) begin
      win_d = w_win_shift;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d   = ST_START;
          samp_d    = '0;
          w_cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (samp_q == S_HI) begin
            if (!maj3(w_win_shift)) begin
              state_d = ST_DATA;
              samp_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;            // glitch, not a start bit
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          samp_d = samp_q + 4'd1;           // wraps 15 -> 0 into next bit
          if (samp_q == S_END) begin
            shreg_d = {maj3(win_q), shreg_q[7:1]};
            if (bit_q == 3'd7) state_d = ST_STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (samp_q == S_HI) begin
            if (maj3(w_win_shift)) begin
              push_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              w_frame_set = 1'b1;
              state_d     = ST_BREAK;
            end
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      win_q       <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      win_q       <= win_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      // A new error in the clearing cycle wins over the clear.
      frame_err_q <= (frame_err_q & ~I_clear) | w_frame_set;
      overrun_q   <= (overrun_q & ~I_clear) | w_overrun_set;
    end
  end

  // The byte is lost only when full and no pop frees a slot this cycle.
  assign w_overrun_set = push_q & w_full & ~(I_read & ~w_empty);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (I_clk),
    .rst_i   (I_rst),
    .wr_i    (push_q),
    .wdata_i (shreg_q),
    .rd_i    (I_read),
    .rdata_o (O_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (O_count)
  );

  assign O_valid     = ~w_empty;
  assign O_frame_err = frame_err_q;
  assign O_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. A reduced clock rate keeps
//            a bit at 96 clocks (DIV=6) so the whole run stays short. The
//            line driver updates a queue model of the FIFO and the error
//            flags; a monitor pops the queue whenever a read is accepted.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ     = 12_000_000;
  localparam int unsigned BAUD       = 115_200;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned DIV        = CLK_HZ / (BAUD * 16);
  localparam int unsigned BIT        = 16 * DIV;
  // Negedges from driving the start bit to the cycle in which the FIFO write
  // is presented: 2 synchroniser flops + IDLE->START, then 148 ticks
  // (start 10, data 8x16, stop 10).
  localparam int unsigned PUSH_NEG   = 3 + 148 * DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rx  = 1'b1;
  logic                rd  = 1'b0;
  logic                clr = 1'b0;
  logic [7:0]          dout;
  logic                valid;
  logic [DEPTH_LOG2:0] cnt;
  logic                ferr;
  logic                ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst),
    .I_uart_rx   (rx),
    .I_read      (rd),
    .I_clear     (clr),
    .O_data      (dout),
    .O_valid     (valid),
    .O_count     (cnt),
    .O_frame_err (ferr),
    .O_overrun   (ovr)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted read must present the oldest expected byte.
  always @(negedge clk) begin
    #2;
    if (rd && valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no entry", dout);
      end else begin
        check("pop_data", {24'h0, dout}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // All tasks below are entered on a negedge and return on a negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_ok);
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
    drive(stop_ok);
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, {27'h0, cnt}, exp_q.size());
    check({tag, "_valid"}, {31'h0, valid}, {31'h0, exp_q.size() != 0});
    check({tag, "_frame_err"}, {31'h0, ferr}, {31'h0, m_ferr});
    check({tag, "_overrun"}, {31'h0, ovr}, {31'h0, m_ovr});
  endtask

  initial begin
    logic [7:0] last;
    int         k;

    idle(3);
    check("reset_data", {24'h0, dout}, 32'h0);
    check_state("reset");
    rst = 1'b0;
    idle(5);

    // Single byte, then one pop empties the FIFO.
    send(8'h55, 1'b1);
    idle(4);
    check("b55_head", {24'h0, dout}, 32'h55);
    check_state("b55");
    pop();
    idle(2);
    check_state("b55_popped");

    // Quarter-bit low pulse on the idle line is rejected as a glitch.
    rx = 1'b0;
    idle(BIT / 4);
    rx = 1'b1;
    idle(2 * BIT);
    check_state("glitch");

    // Bad stop bit followed by a long low, then a clean character.
    send(8'hA3, 1'b0);
    idle(2 * BIT);
    rx = 1'b1;
    idle(BIT);
    check_state("frame");
    send(8'h41, 1'b1);
    idle(4);
    check_state("after_frame");
    pop();
    clear_flags();
    idle(2);
    check_state("frame_cleared");

    // 17 bytes with no reads: the 17th is lost and overrun is raised.
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b1);
    idle(4);
    check_state("overflow");
    repeat (DEPTH) pop();
    idle(2);
    check_state("overflow_drained");
    clear_flags();

    // Full FIFO with a pop in the exact push cycle: no overrun, count holds.
    for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)), 1'b1);
    check_state("refill");
    fork
      send(8'h77, 1'b1);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    idle(4);
    check_state("push_pop_full");
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      last = dout;
      pop();
    end
    check("push_pop_last", {24'h0, last}, 32'h77);

    // Random bytes with random gaps and random pops.
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      idle($urandom_range(0, 20));
      k = $urandom_range(0, 2);
      repeat (k) pop();
      idle(2);
      check_state("random");
    end
    k = exp_q.size();
    repeat (k) pop();

    // Reset during bit 4 of 0xC8 with three bytes queued.
    send(8'h80 | 8'($urandom_range(0, 127)), 1'b1);
    send(8'($urandom_range(0, 255)), 1'b1);
    send(8'($urandom_range(0, 255)), 1'b1);
    check_state("pre_reset");
    begin
      logic [7:0] c8;
      c8 = 8'hC8;
      drive(1'b0);
      for (int i = 0; i < 4; i++) drive(c8[i]);
      rx = c8[4];
    end
    idle(BIT / 2);
    #3;
    rst = 1'b1;
    rx  = 1'b1;
    exp_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    #1;
    check("midreset_data", {24'h0, dout}, 32'h0);
    check_state("midreset");
    idle(2);
    rst = 1'b0;
    idle(BIT);
    send(8'h12, 1'b1);
    idle(4);
    check("after_reset_head", {24'h0, dout}, 32'h12);
    check_state("after_reset");
    pop();
    idle(2);
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
